// File: rtl/mceliece_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : mceliece_pkg
//  Description: Shared types and sizing helpers for the McEliece decryption
//               back-end (error vector streaming and weight check).
//               Contents:
//                 f_num_words  - number of output words for a vector
//                 f_weight_w   - width of a Hamming-weight counter
//                 NW, WEIGHT_W - sizes for the default configuration
//                 state_t      - streamer state encoding
//  Revision   : 1.0 - initial release
// ============================================================================
package mceliece_pkg;

  // Default configuration (mceliece348864).
  localparam int c_n_default    = 3488;
  localparam int c_t_default    = 64;
  localparam int c_word_default = 32;

  // Words needed to carry n bits, WORD bits at a time (ceiling division).
  function automatic int f_num_words(input int n, input int word);
    return (n + word - 1) / word;
  endfunction

  // Bits needed to hold any weight from 0 to n inclusive.
  function automatic int f_weight_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int NW       = f_num_words(c_n_default, c_word_default);
  localparam int WEIGHT_W = f_weight_w(c_n_default);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/error_vec_streamer_popcount.sv
`default_nettype none
// ============================================================================
//  Module     : popcount_word
//  Description: Combinational population count of one WORD-bit word.
//  Ports      : data  (in,  WORD)             word to count
//               count (out, clog2(WORD+1))    number of set bits in data
//  Revision   : 1.0 - initial release
// ============================================================================
module popcount_word #(
  parameter int WORD = 32
) (
  input  logic [WORD-1:0]            data,
  output logic [$clog2(WORD+1)-1:0]  count
);

  localparam int c_cnt_w = $clog2(WORD + 1);

  // Plain sum of the bits; there is no ordering dependency between terms, so
  // synthesis is free to restructure it into a balanced adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < WORD; i++) begin
      count = count + c_cnt_w'(data[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/error_vec_streamer.sv
`default_nettype none
// ============================================================================
//  Module     : error_vec_streamer
//  Description: Captures the recovered error vector from the decryption core
//               on dec_done, streams it out as WORD-bit words over a
//               valid/ready interface (word 0 first, padding bits zero) and
//               reports its Hamming weight plus a pass/fail status.
//  Ports      : clk, rst          clock, asynchronous active-high reset
//               dec_done          capture strobe from the decryption core
//               dec_fail          re-encryption failure flag (captured)
//               error_recovered   N-bit error vector (captured)
//               out_data/valid/ready/last   word stream
//               busy              capture through status report
//               status_valid      one-cycle pulse, weight/weight_ok valid
//               weight, weight_ok Hamming weight and (weight==T && !fail)
//               overrun           sticky: dec_done seen while not idle
//  Revision   : 1.0 - initial release
// ============================================================================
module error_vec_streamer
  import mceliece_pkg::*;
#(
  parameter int N    = 3488,
  parameter int T    = 64,
  parameter int WORD = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec_done,
  input  logic                       dec_fail,
  input  logic [N-1:0]               error_recovered,
  output logic [WORD-1:0]            out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       status_valid,
  output logic [$clog2(N+1)-1:0]     weight,
  output logic                       weight_ok,
  output logic                       overrun
);

  localparam int c_nw       = f_num_words(N, WORD);
  localparam int c_pad_w    = c_nw * WORD;
  localparam int c_idx_w    = (c_nw > 1) ? $clog2(c_nw) : 1;
  localparam int c_base_w   = (c_pad_w > 1) ? $clog2(c_pad_w) : 1;
  localparam int c_weight_w = f_weight_w(N);
  localparam int c_pop_w    = $clog2(WORD + 1);

  localparam logic [c_idx_w-1:0]    c_last_idx = c_idx_w'(c_nw - 1);
  localparam logic [c_weight_w-1:0] c_t        = c_weight_w'(T);

  state_t                  r_state;
  logic [c_pad_w-1:0]      r_vec;
  logic                    r_fail;
  logic [c_idx_w-1:0]      r_idx;
  logic [c_weight_w-1:0]   r_acc;

  logic [c_pad_w-1:0]      w_cap;
  logic                    w_hs;
  logic [c_idx_w-1:0]      w_next_idx;
  logic [c_base_w-1:0]     w_next_base;
  logic [WORD-1:0]         w_next_word;
  logic [c_pop_w-1:0]      w_pop;
  logic [c_weight_w-1:0]   w_acc_next;

  // Capture image: the vector zero-extended to a whole number of words, so
  // the last word carries zeros above bit N-1.
  always_comb begin
    w_cap          = '0;
    w_cap[N-1:0]   = error_recovered;
  end

  assign w_hs        = out_valid & out_ready;
  assign w_next_idx  = r_idx + 1'b1;

  // Word select by indexed part-select on the static capture register; the
  // N-bit register is never shifted.
  assign w_next_base = c_base_w'(int'(w_next_idx) * WORD);
  assign w_next_word = r_vec[w_next_base +: WORD];

  // Popcount of the word currently presented; it is only folded into the
  // accumulator on a handshake.
  popcount_word #(
    .WORD (WORD)
  ) u_popcount (
    .data  (out_data),
    .count (w_pop)
  );

  assign w_acc_next = r_acc + c_weight_w'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_vec        <= '0;
      r_fail       <= 1'b0;
      r_idx        <= '0;
      r_acc        <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      status_valid <= 1'b0;
      weight       <= '0;
      weight_ok    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      status_valid <= 1'b0;

      // Any capture request outside IDLE (including the REPORT cycle) is
      // dropped and remembered until reset.
      if (dec_done && (r_state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (dec_done) begin
            r_vec     <= w_cap;
            r_fail    <= dec_fail;
            r_idx     <= '0;
            r_acc     <= '0;
            out_data  <= w_cap[WORD-1:0];
            out_valid <= 1'b1;
            out_last  <= (c_nw == 1);
            busy      <= 1'b1;
            r_state   <= STREAM;
          end
        end

        STREAM: begin
          // Without a handshake every output register holds its value,
          // which keeps out_data/out_last stable across stalls.
          if (w_hs) begin
            r_acc <= w_acc_next;
            if (out_last) begin
              // Status is registered on entry to REPORT so it is presented
              // during the single REPORT cycle.
              out_valid    <= 1'b0;
              out_last     <= 1'b0;
              weight       <= w_acc_next;
              weight_ok    <= (w_acc_next == c_t) && !r_fail;
              status_valid <= 1'b1;
              r_state      <= REPORT;
            end else begin
              r_idx    <= w_next_idx;
              out_data <= w_next_word;
              out_last <= (w_next_idx == c_last_idx);
            end
          end
        end

        REPORT: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_error_vec_streamer.sv
`default_nettype none
// ============================================================================
//  Module     : tb_error_vec_streamer
//  Description: Self-checking bench for error_vec_streamer with N=40, T=3,
//               WORD=16 (three words per vector).
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_error_vec_streamer;

  localparam int c_n    = 40;
  localparam int c_t    = 3;
  localparam int c_word = 16;
  localparam int c_nw   = 3;

  logic               clk;
  logic               rst;
  logic               dec_done;
  logic               dec_fail;
  logic [c_n-1:0]     error_recovered;
  logic [c_word-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic               status_valid;
  logic [5:0]         weight;
  logic               weight_ok;
  logic               overrun;

  error_vec_streamer #(
    .N    (c_n),
    .T    (c_t),
    .WORD (c_word)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dec_done        (dec_done),
    .dec_fail        (dec_fail),
    .error_recovered (error_recovered),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .busy            (busy),
    .status_valid    (status_valid),
    .weight          (weight),
    .weight_ok       (weight_ok),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  // Observation results of the most recent window.
  logic [c_word-1:0] hs_data[$];
  logic              hs_last[$];
  int                st_cnt;
  int                st_cyc;
  logic [5:0]        st_w;
  logic              st_ok;
  int                busy_cnt;
  int                stall_bad;

  // ---------------- reference model ----------------
  function automatic logic [c_word-1:0] model_word(input logic [c_n-1:0] v, input int i);
    logic [c_word-1:0] w;
    w = '0;
    for (int j = 0; j < c_word; j++) begin
      if (i * c_word + j < c_n) w[j] = v[i * c_word + j];
    end
    return w;
  endfunction

  function automatic int model_weight(input logic [c_n-1:0] v);
    int s;
    s = 0;
    for (int j = 0; j < c_n; j++) s += int'(v[j]);
    return s;
  endfunction

  function automatic logic model_ok(input logic [c_n-1:0] v, input logic f);
    return (model_weight(v) == c_t) && !f;
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_done(input logic [c_n-1:0] v, input logic f);
    error_recovered = v;
    dec_fail        = f;
    dec_done        = 1'b1;
    tick();
    dec_done        = 1'b0;
  endtask

  // Watches ncyc cycles after the capture edge (cycle 1 = first cycle after
  // dec_done was sampled). mode 0: ready high; 1: ready 1,0,0,1,0,1 then high;
  // 2: random ready. inj_cyc > 0 raises dec_done with inj_vec in that cycle.
  task automatic observe(input int ncyc, input int mode, input int inj_cyc,
                         input logic [c_n-1:0] inj_vec);
    logic [c_word-1:0] pd;
    logic pv, pr, pl;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    hs_data.delete();
    hs_last.delete();
    st_cnt = 0; st_cyc = -1; st_w = '0; st_ok = 1'b0;
    busy_cnt = 0; stall_bad = 0;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc <= 6) ? pat[cyc-1] : 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (cyc == inj_cyc) begin
        dec_done        = 1'b1;
        error_recovered = inj_vec;
      end else begin
        dec_done = 1'b0;
      end
      if (pv && !pr) begin
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) stall_bad++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        hs_data.push_back(out_data);
        hs_last.push_back(out_last);
      end
      if (status_valid === 1'b1) begin
        st_cnt++;
        st_cyc = cyc;
        st_w   = weight;
        st_ok  = weight_ok;
      end
      if (busy === 1'b1) busy_cnt++;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      tick();
    end
    dec_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [27:0] snap;
    rst = 1'b1;
    tick();
    tick();
    snap = {out_data, out_valid, out_last, busy, status_valid, weight, weight_ok, overrun};
    n_chk++;
    if (snap !== 28'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", snap);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [c_n-1:0] v;
    logic [c_word-1:0] exp_w [3];
    v = '0; v[0] = 1'b1; v[17] = 1'b1; v[39] = 1'b1;
    exp_w = '{16'h0001, 16'h0002, 16'h0080};
    send_done(v, 1'b0);
    observe(10, 0, 0, '0);
    n_chk++;
    if (hs_data.size() != c_nw) begin
      n_err++;
      $display("FAIL basic_hs_count: got %0d want %0d", hs_data.size(), c_nw);
    end
    for (int i = 0; i < c_nw && i < hs_data.size(); i++) begin
      n_chk++;
      if (hs_data[i] !== exp_w[i] || exp_w[i] !== model_word(v, i)) begin
        n_err++;
        $display("FAIL basic_word%0d: got %h want %h", i, hs_data[i], exp_w[i]);
      end
      n_chk++;
      if (hs_last[i] !== (i == c_nw - 1)) begin
        n_err++;
        $display("FAIL basic_last%0d: got %b want %b", i, hs_last[i], (i == c_nw - 1));
      end
    end
    n_chk++;
    if (st_cnt != 1 || st_w !== 6'(model_weight(v)) || st_ok !== 1'b1) begin
      n_err++;
      $display("FAIL basic_status: got cnt=%0d w=%0d ok=%b want cnt=1 w=3 ok=1", st_cnt, st_w, st_ok);
    end
    // dec_done in cycle 0, status in cycle 4: five cycles inclusive.
    n_chk++;
    if (st_cyc + 1 != 5) begin
      n_err++;
      $display("FAIL basic_latency: got %0d want 5", st_cyc + 1);
    end
    n_chk++;
    if (busy_cnt != c_nw + 1) begin
      n_err++;
      $display("FAIL basic_busy_cycles: got %0d want %0d", busy_cnt, c_nw + 1);
    end
    n_chk++;
    if (weight !== 6'd3 || weight_ok !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL basic_hold: got w=%0d ok=%b busy=%b ovr=%b want 3 1 0 0", weight, weight_ok, busy, overrun);
    end
  endtask

  task automatic test_dec_fail();
    logic [c_n-1:0] v;
    v = '0; v[0] = 1'b1; v[17] = 1'b1; v[39] = 1'b1;
    send_done(v, 1'b1);
    observe(10, 0, 0, '0);
    n_chk++;
    if (hs_data.size() != c_nw) begin
      n_err++;
      $display("FAIL fail_hs_count: got %0d want %0d", hs_data.size(), c_nw);
    end
    for (int i = 0; i < c_nw && i < hs_data.size(); i++) begin
      n_chk++;
      if (hs_data[i] !== model_word(v, i)) begin
        n_err++;
        $display("FAIL fail_word%0d: got %h want %h", i, hs_data[i], model_word(v, i));
      end
    end
    n_chk++;
    if (st_cnt != 1 || st_w !== 6'd3 || st_ok !== 1'b0) begin
      n_err++;
      $display("FAIL fail_status: got cnt=%0d w=%0d ok=%b want cnt=1 w=3 ok=0", st_cnt, st_w, st_ok);
    end
  endtask

  task automatic test_stall();
    logic [c_n-1:0] v;
    v = '0; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1; v[4] = 1'b1;
    send_done(v, 1'b0);
    observe(14, 1, 0, '0);
    n_chk++;
    if (stall_bad != 0) begin
      n_err++;
      $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_bad);
    end
    n_chk++;
    if (hs_data.size() != c_nw) begin
      n_err++;
      $display("FAIL stall_hs_count: got %0d want %0d", hs_data.size(), c_nw);
    end
    for (int i = 0; i < c_nw && i < hs_data.size(); i++) begin
      n_chk++;
      if (hs_data[i] !== model_word(v, i) || hs_last[i] !== (i == c_nw - 1)) begin
        n_err++;
        $display("FAIL stall_word%0d: got %h/%b want %h/%b", i, hs_data[i], hs_last[i],
                 model_word(v, i), (i == c_nw - 1));
      end
    end
    n_chk++;
    if (st_cnt != 1 || st_w !== 6'd4 || st_ok !== 1'b0) begin
      n_err++;
      $display("FAIL stall_status: got cnt=%0d w=%0d ok=%b want cnt=1 w=4 ok=0", st_cnt, st_w, st_ok);
    end
  endtask

  task automatic test_overrun();
    logic [c_n-1:0] va, vb;
    va = '0; va[5] = 1'b1; va[20] = 1'b1; va[33] = 1'b1;
    vb = '1;
    send_done(va, 1'b0);
    observe(12, 0, 2, vb);
    n_chk++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    n_chk++;
    if (hs_data.size() != c_nw) begin
      n_err++;
      $display("FAIL overrun_hs_count: got %0d want %0d", hs_data.size(), c_nw);
    end
    for (int i = 0; i < c_nw && i < hs_data.size(); i++) begin
      n_chk++;
      if (hs_data[i] !== model_word(va, i)) begin
        n_err++;
        $display("FAIL overrun_word%0d: got %h want %h", i, hs_data[i], model_word(va, i));
      end
    end
    n_chk++;
    if (st_cnt != 1 || st_w !== 6'(model_weight(va)) || st_ok !== model_ok(va, 1'b0)) begin
      n_err++;
      $display("FAIL overrun_status: got cnt=%0d w=%0d ok=%b want cnt=1 w=%0d ok=%b",
               st_cnt, st_w, st_ok, model_weight(va), model_ok(va, 1'b0));
    end
    send_done(vb, 1'b0);
    observe(10, 0, 0, '0);
    n_chk++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_abort();
    logic [c_n-1:0] v, vn;
    logic [27:0] snap;
    int bad;
    v = '1;
    vn = '0; vn[8] = 1'b1; vn[16] = 1'b1; vn[32] = 1'b1;
    out_ready = 1'b1;
    send_done(v, 1'b0);
    tick();                        // second word now presented
    rst = 1'b1;
    #1;
    snap = {out_data, out_valid, out_last, busy, status_valid, weight, weight_ok, overrun};
    n_chk++;
    if (snap !== 28'd0) begin
      n_err++;
      $display("FAIL abort_async_reset: got %h want 0", snap);
    end
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (status_valid !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (status_valid !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL abort_no_status: got %0d bad cycles want 0", bad);
    end
    send_done(vn, 1'b0);
    observe(10, 0, 0, '0);
    n_chk++;
    if (hs_data.size() != c_nw) begin
      n_err++;
      $display("FAIL abort_hs_count: got %0d want %0d", hs_data.size(), c_nw);
    end
    for (int i = 0; i < c_nw && i < hs_data.size(); i++) begin
      n_chk++;
      if (hs_data[i] !== model_word(vn, i)) begin
        n_err++;
        $display("FAIL abort_word%0d: got %h want %h", i, hs_data[i], model_word(vn, i));
      end
    end
    n_chk++;
    if (st_cnt != 1 || st_w !== 6'd3 || st_ok !== 1'b1) begin
      n_err++;
      $display("FAIL abort_status: got cnt=%0d w=%0d ok=%b want cnt=1 w=3 ok=1", st_cnt, st_w, st_ok);
    end
  endtask

  task automatic test_all_ones();
    logic [c_n-1:0] v;
    v = '1;
    send_done(v, 1'b0);
    observe(10, 0, 0, '0);
    n_chk++;
    if (hs_data.size() != c_nw) begin
      n_err++;
      $display("FAIL ones_hs_count: got %0d want %0d", hs_data.size(), c_nw);
    end else begin
      n_chk++;
      if (hs_data[2] !== 16'h00FF || hs_data[0] !== 16'hFFFF || hs_data[1] !== 16'hFFFF) begin
        n_err++;
        $display("FAIL ones_words: got %h %h %h want ffff ffff 00ff", hs_data[0], hs_data[1], hs_data[2]);
      end
    end
    n_chk++;
    if (st_cnt != 1 || st_w !== 6'd40 || st_ok !== 1'b0) begin
      n_err++;
      $display("FAIL ones_status: got cnt=%0d w=%0d ok=%b want cnt=1 w=40 ok=0", st_cnt, st_w, st_ok);
    end
  endtask

  task automatic test_random();
    logic [c_n-1:0] v;
    logic [31:0] r;
    logic f;
    for (int it = 0; it < 8; it++) begin
      if (it % 2 == 0) begin
        r = $urandom; v[31:0] = r;
        r = $urandom; v[39:32] = r[7:0];
      end else begin
        v = '0;
        while (model_weight(v) < c_t) v[$urandom_range(0, c_n - 1)] = 1'b1;
      end
      f = 1'($urandom_range(0, 1));
      send_done(v, f);
      observe(60, 2, 0, '0);
      n_chk++;
      if (stall_bad != 0 || hs_data.size() != c_nw) begin
        n_err++;
        $display("FAIL rand%0d_stream: got stalls_bad=%0d hs=%0d want 0 and %0d",
                 it, stall_bad, hs_data.size(), c_nw);
      end
      for (int i = 0; i < c_nw && i < hs_data.size(); i++) begin
        n_chk++;
        if (hs_data[i] !== model_word(v, i) || hs_last[i] !== (i == c_nw - 1)) begin
          n_err++;
          $display("FAIL rand%0d_word%0d: got %h/%b want %h/%b", it, i, hs_data[i], hs_last[i],
                   model_word(v, i), (i == c_nw - 1));
        end
      end
      n_chk++;
      if (st_cnt != 1 || st_w !== 6'(model_weight(v)) || st_ok !== model_ok(v, f)) begin
        n_err++;
        $display("FAIL rand%0d_status: got cnt=%0d w=%0d ok=%b want cnt=1 w=%0d ok=%b",
                 it, st_cnt, st_w, st_ok, model_weight(v), model_ok(v, f));
      end
    end
  endtask

  initial begin
    n_chk           = 0;
    n_err           = 0;
    rst             = 1'b1;
    dec_done        = 1'b0;
    dec_fail        = 1'b0;
    error_recovered = '0;
    out_ready       = 1'b0;

    test_reset();
    test_basic();
    test_dec_fail();
    test_stall();
    test_overrun();
    test_reset_abort();
    test_all_ones();
    test_random();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/error_vec_streamer.md
Name: error_vec_streamer

Overview:
- Sits directly downstream of the decryption core.
- On the core's `done` pulse it captures the N-bit `error_recovered` vector and the `decryption_fail` flag.
- Streams the vector out as WORD-bit words over a valid/ready interface, for the session-key hash stage and the host readout path.
- While streaming, it accumulates the Hamming weight and reports a final status: weight == t and no re-encryption failure.

Parameters:
- N, 3488, error vector length (code length).
- t, 64, expected error weight.
- WORD, 32, output word width; 1 <= WORD <= N.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dec_done  in  1  one-cycle pulse from the decryption core; error_recovered and dec_fail are valid in this cycle.
- dec_fail  in  1  re-encryption failure flag from the decryption core.
- error_recovered  in  N  recovered error vector; bit 0 = position 0.
- out_data  out  WORD  current output word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_last  out  1  high with the final word of a vector.
- busy  out  1  high from capture until status is reported.
- status_valid  out  1  one-cycle pulse: weight and weight_ok are valid.
- weight  out  clog2(N+1)  Hamming weight of the captured vector; held until the next capture.
- weight_ok  out  1  (weight == t) && !captured dec_fail; held until the next capture.
- overrun  out  1  sticky: dec_done arrived while busy; cleared only by rst.

Behaviour:
- NW = ceil(N/WORD). Word i = captured bits [i*WORD +: WORD]. The last word's bits at index >= N are driven 0.
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, status_valid=0, weight=0, weight_ok=0, overrun=0. State = IDLE, word index = 0.
- On rst, all of the above take their reset values immediately; any in-flight transfer is abandoned; no status is produced.
- States: IDLE -> STREAM -> REPORT -> IDLE.
- IDLE:
  - dec_done=1: register the vector and dec_fail, clear the weight accumulator, index=0, go to STREAM.
  - out_valid=1 with word 0 in the next cycle (1-cycle latency).
  - busy=1 from that same next cycle.
- STREAM:
  - out_valid=1.
  - out_data and out_last must stay stable while out_valid && !out_ready.
  - On handshake: add popcount(current word) to the accumulator and increment the index.
  - out_last = (index == NW-1).
  - Handshake on the last word: out_valid=0 next cycle, go to REPORT.
  - Back-to-back handshakes are supported: one word per cycle when out_ready is held high.
- REPORT (one cycle):
  - Drive weight = accumulator and weight_ok per the formula above, with status_valid=1.
  - Go to IDLE; busy=0 in the following cycle.
- dec_done while not IDLE: ignored, overrun <= 1. The captured vector is unaffected.
- dec_done in the same cycle the REPORT state exits: also ignored, since the state is not IDLE.
- Minimum vector-to-vector spacing: NW+2 cycles.
- Accumulator width is clog2(N+1) and cannot overflow.
- Per-word popcount is a combinational adder tree over WORD bits.
- Throughput with out_ready tied high: total busy time = NW+1 cycles per vector.

Decomposition:
- Shared package (mceliece_pkg): localparams NW and WEIGHT_W = clog2(N+1); state encoding enum {IDLE, STREAM, REPORT}.
- One sub-module, popcount_word: parameter WORD, combinational, output width clog2(WORD+1).
- Capture register and word mux stay in the top module, with index-selected part-select. No shifting of the N-bit register, to save area at N=3488.

Test Plan (bench params N=40, t=3, WORD=16, so NW=3):
- Vector with bits 0, 17, 39 set; dec_fail=0; out_ready=1 → words 0x0001, 0x0002, 0x0080; out_last on the 3rd word; status_valid pulse with weight=3 and weight_ok=1; dec_done-to-status = 5 cycles.
- Same vector with dec_fail=1 → same words; weight=3, weight_ok=0.
- Vector with bits 1, 2, 3, 4 set; out_ready toggled 1,0,0,1,0,1 → out_data and out_last stable during stalls; exactly 3 handshakes; weight=4, weight_ok=0.
- Second dec_done issued 2 cycles after the first → overrun=1 and sticky; the stream carries only the first vector; exactly one status pulse.
- rst asserted during the 2nd word, then a new vector captured → all outputs at reset values immediately; no status for the aborted vector; the new vector streams from word 0 and reports correctly.
- All-ones vector → last word = 0x00FF (padding zero); weight=40, weight_ok=0.
